// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the instruction-fetch
//               path and the load/store path of a multicycle RISC-V core.
//               One request is serviced at a time. Data requests win by
//               default; a saturating streak counter lets a waiting fetch win
//               after STARVE_MAX contested data grants. Each access holds the
//               memory for MEM_LAT cycles, then a one-cycle response pulse is
//               issued to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  // instruction-fetch requester
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DATA_W-1:0] I_RDATA,
  // data (load/store) requester
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_DONE,
  output logic [DATA_W-1:0] D_RDATA,
  // memory side
  output logic              MEM_EN,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  // status
  output logic              BUSY,
  output logic              OWNER
);

  // Counter is preloaded with MEM_LAT-1 so that MEM_LAT ACCESS cycles elapse.
  localparam logic [2:0] c_LAT_LOAD = 3'(MEM_LAT - 1);
  localparam logic [3:0] c_STARVE   = 4'(STARVE_MAX);
  localparam logic [3:0] c_STREAK_SAT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [2:0]          r_cnt;
  logic [3:0]          r_streak;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_owner;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  // Arbitration candidates. Gated by RESET so no grant is visible while the
  // block is held in reset, even though requests may already be asserted.
  logic                w_i_win;
  logic                w_d_win;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_last_access;

  // A fetch wins when it is alone, or when the data side has starved it long
  // enough; otherwise any pending data request wins.
  always_comb begin
    w_i_win = 1'b0;
    w_d_win = 1'b0;
    if (!RESET) begin
      w_i_win = I_REQ && (!D_REQ || (r_streak == c_STARVE));
      w_d_win = D_REQ && !w_i_win;
    end
  end

  assign w_last_access = (r_state == ST_ACCESS) && (r_cnt == 3'd0);

  // FSM state register; async reset drops any access in flight immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-state outputs; grants only ever appear in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    MEM_EN       = 1'b0;
    MEM_WR       = 1'b0;
    BUSY         = 1'b0;
    I_RVALID     = 1'b0;
    D_DONE       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_i = w_i_win;
        w_grant_d = w_d_win;
        if (w_i_win || w_d_win) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        MEM_EN = 1'b1;
        MEM_WR = r_we;
        BUSY   = 1'b1;
        if (r_cnt == 3'd0) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        BUSY         = 1'b1;
        I_RVALID     = !r_owner;
        D_DONE       = r_owner;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign I_GNT = w_grant_i;
  assign D_GNT = w_grant_d;

  // Request latches and access counter: captured once per grant, held stable
  // for the whole access so the requester may move on after its GNT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_owner <= 1'b0;
      r_cnt   <= 3'd0;
    end else begin
      if (w_grant_d) begin
        r_addr  <= D_ADDR;
        r_wdata <= D_WDATA;
        r_we    <= D_WE;
        r_owner <= 1'b1;
        r_cnt   <= c_LAT_LOAD;
      end else if (w_grant_i) begin
        r_addr  <= I_ADDR;
        r_we    <= 1'b0;
        r_owner <= 1'b0;
        r_cnt   <= c_LAT_LOAD;
      end else if ((r_state == ST_ACCESS) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Starvation streak: counts data grants taken while a fetch was waiting.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_streak <= 4'd0;
    end else if (w_grant_i) begin
      r_streak <= 4'd0;
    end else if (w_grant_d && I_REQ && (r_streak != c_STREAK_SAT)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  // Read-data registers: loaded on the final ACCESS edge of a read, and held
  // until the next read by the same owner (stores never touch D_RDATA).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (w_last_access && !r_we) begin
      if (r_owner) begin
        r_d_rdata <= MEM_RDATA;
      end else begin
        r_i_rdata <= MEM_RDATA;
      end
    end
  end

  assign I_RDATA   = r_i_rdata;
  assign D_RDATA   = r_d_rdata;
  assign MEM_ADDR  = r_addr;
  assign MEM_WDATA = r_wdata;
  assign OWNER     = r_owner;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer/arbiter that shares the single-ported main memory between the instruction-fetch path (IR load) and the data path (LD/SD) of the multicycle RISC-V core. It accepts one request at a time from either requester. It drives the memory for a fixed number of wait cycles, then returns read data or a write acknowledgment with a one-cycle valid pulse. Data requests have priority, with a starvation guard so fetches always make progress.

## Interface
- ADDR_W, 64, address width of both requesters and memory
- DATA_W, 64, data width
- MEM_LAT, 2, memory access cycles (legal 1..7); MEM_RDATA valid in the last of them
- STARVE_MAX, 4, consecutive contested data grants after which a pending fetch wins (legal 1..15)

- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-high
- I_REQ  in  1  fetch request; held until I_GNT
- I_ADDR  in  ADDR_W  fetch address
- I_GNT  out  1  fetch granted (combinational, IDLE only)
- I_RVALID  out  1  one-cycle pulse, I_RDATA valid
- I_RDATA  out  DATA_W  fetched word
- D_REQ  in  1  data request; held until D_GNT
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_GNT  out  1  data request granted (combinational, IDLE only)
- D_DONE  out  1  one-cycle pulse, load data valid or store complete
- D_RDATA  out  DATA_W  loaded word; updated only by loads
- MEM_EN  out  1  memory access enable
- MEM_WR  out  1  memory write strobe
- MEM_ADDR  out  ADDR_W  latched address
- MEM_WDATA  out  DATA_W  latched store data
- MEM_RDATA  in  DATA_W  memory read data
- BUSY  out  1  high in ACCESS and RESP
- OWNER  out  1  0 = fetch, 1 = data; meaningful while BUSY

## Operation
- The FSM has three states: IDLE, ACCESS, and RESP.
- IDLE: if no request is pending, stay in IDLE. Otherwise, pick a winner:
  - D wins by default.
  - I wins if only I_REQ is high.
  - I wins if both requests are high and streak == STARVE_MAX.
- On a win, the winner's GNT is high for that cycle only. At the next edge, latch the address, wdata, we, and owner, load the counter with MEM_LAT-1, and go to ACCESS.
- ACCESS: MEM_EN=1, and MEM_WR=we for every ACCESS cycle. MEM_ADDR and MEM_WDATA come from the latches and are stable for the whole access.
  - If counter is nonzero, decrement it.
  - If counter is zero, capture MEM_RDATA (loads and fetches only) into the owner's RDATA register at the edge and go to RESP.
- RESP: pulse I_RVALID (owner 0) or D_DONE (owner 1). MEM_EN=0. Next state is IDLE unconditionally; no arbitration happens in RESP.
- Streak counter (4-bit, saturating):
  - On a D grant while I_REQ is high: increment.
  - On an I grant: clear.
  - On a D grant with I_REQ low: unchanged.
- If a REQ drops before its GNT, no access is made and nothing is latched. After GNT, the requester may change or drop its REQ and address freely.
- I_RDATA and D_RDATA hold their values until the next read for the same owner.

## Timing
- Grant to response: MEM_LAT+1 cycles. GNT in cycle t; ACCESS in t+1..t+MEM_LAT; RVALID/D_DONE in t+MEM_LAT+1.
- Earliest next GNT is t+MEM_LAT+2, so peak throughput is one access per MEM_LAT+2 cycles.
- A store is the same length as a load. D_DONE marks completion; D_RDATA is unchanged by a store.
- Reset values:
  - State IDLE, streak 0, all latches 0.
  - Outputs: all GNT/valid/MEM_EN/MEM_WR/BUSY/OWNER 0, all data and address outputs 0.
- Reset mid-access: MEM_EN and MEM_WR drop asynchronously, and no response pulse is issued.
- Requests asserted during ACCESS or RESP wait and are arbitrated in the next IDLE cycle.

## Test plan
- Fetch, MEM_LAT=2: I_REQ with I_ADDR=0x40 and memory word 0x00500093 → I_GNT at t, MEM_EN in t+1..t+2 with MEM_ADDR=0x40, I_RVALID at t+3 with I_RDATA=0x00500093.
- Store then load: D_WE=1, D_ADDR=0x100, D_WDATA=0xDEADBEEF → MEM_WR high for 2 cycles, then D_DONE. Then D_WE=0 at the same address → D_DONE with D_RDATA=0xDEADBEEF.
- Contention: I_REQ and D_REQ both high continuously → D granted 4 times, 5th grant goes to I, streak returns to 0, then D is granted again.
- Early withdrawal: assert I_REQ during a data ACCESS, drop it before IDLE → no I_GNT, no memory access at the fetch address.
- Reset in the 1st ACCESS cycle of a load → MEM_EN falls in the same cycle, no D_DONE. A fresh request after reset completes normally in MEM_LAT+1 cycles.
- MEM_LAT=1 build: fetch → I_RVALID two cycles after I_GNT; back-to-back requests granted every 3 cycles.
